// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game controller: FSM state
// encoding, direction codes and grid geometry.
package snake_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    EVAL  = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam int COLS = 32;
  localparam int ROWS = 24;

  // Opposite directions share the axis bit and differ in the sense bit.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_ctrl_if.sv
// Controller <-> snake datapath link: advance/load strobes, direction and
// length going out, wall-hit flag and head/food cells coming back.
interface snake_dp_if #(
  parameter int NUM_LEN = 10,
  parameter int MAX_LEN = 16
);
  // Wide enough to hold MAX_LEN itself.
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               step;
  logic               load;
  logic [1:0]         di;
  logic [LEN_W-1:0]   len;
  logic               should_stop;
  logic [NUM_LEN-1:0] head_pos;
  logic [NUM_LEN-1:0] food_pos;

  modport master (
    output step, load, di, len,
    input  should_stop, head_pos, food_pos
  );

  modport slave (
    input  step, load, di, len,
    output should_stop, head_pos, food_pos
  );
endinterface

// File: rtl/snake_tick_gen.sv
// Move-tick counter: counts enabled cycles modulo TICK_DIV and flags the
// terminal count; holds its value while disabled.
module snake_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/snake_ctrl.sv
// Game sequencer for the snake datapath: move tick, direction latch,
// length/score bookkeeping and the run/pause/over state machine.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int INIT_LEN = 4,
  parameter int MAX_LEN  = 16,
  parameter int NUM_LEN  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] btn_dir,
  snake_dp_if.master dp,
  output logic [7:0] score,
  output logic       food_eaten,
  output state_t     state
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t             state_next;
  logic [1:0]         di_q, di_next, pend_q, pend_next, dir_cand;
  logic [LEN_W-1:0]   len_q, len_next;
  logic [7:0]         score_next;
  logic               step_q, step_next, load_q, load_next, eat_next;
  logic               tick, tick_en;
  logic [NUM_LEN-1:0] head, food;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] v);
    if (v >= LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    return v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_score(input logic [7:0] v);
    if (v == 8'hFF) return v;
    return v + 8'd1;
  endfunction

  assign head = dp.head_pos;
  assign food = dp.food_pos;

  // A start or pause pulse in RUN freezes the count for that cycle.
  assign tick_en = (state == RUN) && !btn_start && !btn_pause;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .clr (btn_start),
    .tc  (tick)
  );

  always_comb begin
    dir_cand = DIR_DOWN;
    if (btn_dir[0])      dir_cand = DIR_LEFT;
    else if (btn_dir[1]) dir_cand = DIR_RIGHT;
    else if (btn_dir[2]) dir_cand = DIR_UP;
  end

  always_comb begin
    state_next = state;
    di_next    = di_q;
    pend_next  = pend_q;
    len_next   = len_q;
    score_next = score;
    load_next  = 1'b0;
    eat_next   = 1'b0;

    if ((state inside {RUN, STEP, EVAL, PAUSE}) && (btn_dir != 4'b0000) &&
        !is_reverse(dir_cand, di_q)) begin
      pend_next = dir_cand;
    end

    if (btn_start) begin
      state_next = RUN;
      load_next  = 1'b1;
      len_next   = LEN_W'(INIT_LEN);
      score_next = 8'd0;
      di_next    = DIR_RIGHT;
      pend_next  = DIR_RIGHT;
    end else begin
      case (state)
        RUN: begin
          if (btn_pause) begin
            state_next = PAUSE;
          end else if (tick) begin
            state_next = STEP;
            di_next    = pend_q;
          end
        end
        STEP: state_next = EVAL;
        EVAL: begin
          if (dp.should_stop) begin
            state_next = OVER;
          end else begin
            if (head == food) begin
              len_next   = sat_len(len_q);
              score_next = sat_score(score);
              eat_next   = 1'b1;
            end
            state_next = RUN;
          end
        end
        PAUSE: if (btn_pause) state_next = RUN;
        default: ;
      endcase
    end

    step_next = (state_next == STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      di_q       <= DIR_RIGHT;
      pend_q     <= DIR_RIGHT;
      len_q      <= LEN_W'(INIT_LEN);
      score      <= 8'd0;
      step_q     <= 1'b0;
      load_q     <= 1'b0;
      food_eaten <= 1'b0;
    end else begin
      state      <= state_next;
      di_q       <= di_next;
      pend_q     <= pend_next;
      len_q      <= len_next;
      score      <= score_next;
      step_q     <= step_next;
      load_q     <= load_next;
      food_eaten <= eat_next;
    end
  end

  assign dp.step = step_q;
  assign dp.load = load_q;
  assign dp.di   = di_q;
  assign dp.len  = len_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with a 4-cycle move tick.
module tb_snake_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [3:0] btn_dir = 4'b0000;
  logic [7:0] score;
  logic       food_eaten;
  state_t     state;

  int n_chk  = 0;
  int n_pass = 0;
  int n;
  int eat_cnt;

  snake_dp_if #(.NUM_LEN(10), .MAX_LEN(16)) dp ();

  snake_ctrl #(
    .TICK_DIV(4), .INIT_LEN(4), .MAX_LEN(16), .NUM_LEN(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_dir    (btn_dir),
    .dp         (dp),
    .score      (score),
    .food_eaten (food_eaten),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance until step is seen high; n = cycles taken, -1 if not within max.
  task automatic wait_step(input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (dp.step === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_state"}, 32'(state), 32'(IDLE));
    chk({pfx, "_step"},  32'(dp.step), 0);
    chk({pfx, "_load"},  32'(dp.load), 0);
    chk({pfx, "_eat"},   32'(food_eaten), 0);
    chk({pfx, "_di"},    32'(dp.di), 1);
    chk({pfx, "_len"},   32'(dp.len), 4);
    chk({pfx, "_score"}, 32'(score), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dp.should_stop = 1'b0;
    dp.head_pos    = 10'd0;
    dp.food_pos    = 10'd5;
    cyc();
    cyc();
    check_reset("rst");
    rst = 1'b0;
    cyc();

    // Start: load pulse, initial length and direction, 6-cycle move period
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    chk("start_state", 32'(state), 32'(RUN));
    chk("start_load",  32'(dp.load), 1);
    chk("start_len",   32'(dp.len), 4);
    chk("start_di",    32'(dp.di), 1);
    wait_step(10, n);
    chk("first_step_lat", n, 4);
    wait_step(10, n);
    chk("step_period_a", n, 6);
    wait_step(10, n);
    chk("step_period_b", n, 6);

    // Reverse (left while right) dropped, up accepted, left beats down
    btn_dir = 4'b0001;
    cyc();
    btn_dir = 4'b0000;
    wait_step(10, n);
    chk("rev_dropped_di", 32'(dp.di), 1);
    btn_dir = 4'b0100;
    cyc();
    btn_dir = 4'b0000;
    chk("up_not_yet", 32'(dp.di), 1);
    wait_step(10, n);
    chk("up_at_step", 32'(dp.di), 2);
    btn_dir = 4'b1001;
    cyc();
    btn_dir = 4'b0000;
    wait_step(10, n);
    chk("prio_left_di", 32'(dp.di), 0);
    chk("no_eat_score", 32'(score), 0);
    cyc();
    cyc();

    // Thirteen eats from length 4: length saturates at 16
    dp.head_pos = 10'd5;
    eat_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      wait_step(10, n);
      cyc();
      if (food_eaten === 1'b1) eat_cnt++;
      cyc();
      if (food_eaten === 1'b1) eat_cnt++;
      if (i == 10) chk("len_15", 32'(dp.len), 15);
    end
    dp.head_pos = 10'd0;
    chk("len_sat", 32'(dp.len), 16);
    chk("score_13", 32'(score), 13);
    chk("eat_pulses", eat_cnt, 13);
    cyc();
    chk("eat_one_cycle", 32'(food_eaten), 0);

    // Wall hit ends the game; restart clears score and length
    wait_step(10, n);
    dp.should_stop = 1'b1;
    cyc();
    cyc();
    dp.should_stop = 1'b0;
    chk("over_state", 32'(state), 32'(OVER));
    wait_step(20, n);
    chk("over_no_step", 32'(n == -1), 1);
    btn_start = 1'b1;
    cyc();
    btn_start = 1'b0;
    chk("restart_state", 32'(state), 32'(RUN));
    chk("restart_score", 32'(score), 0);
    chk("restart_len",   32'(dp.len), 4);
    chk("restart_load",  32'(dp.load), 1);

    // Pause at count 2, hold, resume: two counts left before step
    cyc();
    cyc();
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    chk("pause_state", 32'(state), 32'(PAUSE));
    wait_step(20, n);
    chk("pause_no_step", 32'(n == -1), 1);
    btn_pause = 1'b1;
    cyc();
    btn_pause = 1'b0;
    chk("resume_state", 32'(state), 32'(RUN));
    wait_step(10, n);
    chk("resume_step_lat", n, 2);
    cyc();
    cyc();

    // Start and pause together: start wins
    btn_start = 1'b1;
    btn_pause = 1'b1;
    cyc();
    btn_start = 1'b0;
    btn_pause = 1'b0;
    chk("start_prio_state", 32'(state), 32'(RUN));
    chk("start_prio_load",  32'(dp.load), 1);

    // Build up non-reset values, then reset during STEP
    btn_dir = 4'b0100;
    dp.head_pos = 10'd5;
    cyc();
    btn_dir = 4'b0000;
    wait_step(10, n);
    chk("pre_rst_di", 32'(dp.di), 2);
    cyc();
    cyc();
    dp.head_pos = 10'd0;
    chk("pre_rst_score", 32'(score), 1);
    wait_step(10, n);
    chk("pre_rst_in_step", 32'(state), 32'(STEP));
    rst = 1'b1;
    cyc();
    check_reset("midrst");
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
